// File: rtl/calib_corr_multi_if.sv
// Bundle of ADC, configuration and result-handshake signals between the
// register file / front end (master) and the multi-channel correlator (slave).
interface calib_corr_multi_if #(
    parameter int NCH     = 4,
    parameter int ADC_W   = 2,
    parameter int PHASE_W = 32,
    parameter int ACC_W   = 32,
    parameter int CYC_W   = 32,
    parameter int PER_W   = 32
);
    logic [NCH*ADC_W-1:0]   adc_data;
    logic                   sec_pulse_ed;
    logic                   cfg_enable;
    logic                   cfg_epoch_sel;
    logic                   cfg_phase_rst;
    logic [PER_W-1:0]       cfg_period;
    logic [NCH*PHASE_W-1:0] cfg_rate;
    logic                   res_ack;
    logic                   ovr_clr;
    logic                   res_valid;
    logic                   res_overrun;
    logic [NCH-1:0]         res_sat;
    logic [NCH*ACC_W-1:0]   res_i;
    logic [NCH*ACC_W-1:0]   res_q;
    logic [NCH*PHASE_W-1:0] res_phase;
    logic [NCH*CYC_W-1:0]   res_cycles;

    modport master (
        output adc_data, sec_pulse_ed, cfg_enable, cfg_epoch_sel, cfg_phase_rst,
               cfg_period, cfg_rate, res_ack, ovr_clr,
        input  res_valid, res_overrun, res_sat, res_i, res_q, res_phase, res_cycles
    );

    modport slave (
        input  adc_data, sec_pulse_ed, cfg_enable, cfg_epoch_sel, cfg_phase_rst,
               cfg_period, cfg_rate, res_ack, ovr_clr,
        output res_valid, res_overrun, res_sat, res_i, res_q, res_phase, res_cycles
    );
endinterface

// File: rtl/calib_corr_multi.sv
// Multi-channel NCO I/Q correlator: per-channel mixing and saturating accumulation,
// epoch snapshots of I/Q/phase/cycle count, and a valid/ack result handshake.
module calib_corr_multi #(
    parameter int NCH     = 4,
    parameter int ADC_W   = 2,
    parameter int PHASE_W = 32,
    parameter int ACC_W   = 32,
    parameter int CYC_W   = 32,
    parameter int PER_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    calib_corr_multi_if.slave bus
);
    localparam int PW = ADC_W + 2;

    logic [PER_W-1:0]        r_per;
    logic [PHASE_W-1:0]      r_phase [NCH];
    logic signed [ACC_W-1:0] r_acc_i [NCH];
    logic signed [ACC_W-1:0] r_acc_q [NCH];
    logic [CYC_W-1:0]        r_cyc   [NCH];
    logic [NCH-1:0]          r_sat;
    logic [NCH*ACC_W-1:0]    r_res_i;
    logic [NCH*ACC_W-1:0]    r_res_q;
    logic [NCH*PHASE_W-1:0]  r_res_phase;
    logic [NCH*CYC_W-1:0]    r_res_cyc;
    logic [NCH-1:0]          r_res_sat;
    logic                    r_valid;
    logic                    r_ovr;

    logic                    w_per_last;
    logic                    w_ep;
    logic [PHASE_W:0]        w_nxt     [NCH];
    logic [CYC_W-1:0]        w_cyc_nxt [NCH];
    logic signed [ACC_W-1:0] w_acc_i   [NCH];
    logic signed [ACC_W-1:0] w_acc_q   [NCH];
    logic [NCH-1:0]          w_sat_now;

    function automatic logic signed [2:0] cos_lut(input logic [2:0] o);
        case (o)
            3'd0, 3'd7: return 3'sb010;
            3'd1, 3'd6: return 3'sb001;
            3'd2, 3'd5: return 3'sb111;
            default:    return 3'sb110;
        endcase
    endfunction

    function automatic logic signed [2:0] sin_lut(input logic [2:0] o);
        case (o)
            3'd0, 3'd3: return 3'sb001;
            3'd1, 3'd2: return 3'sb010;
            3'd4, 3'd7: return 3'sb111;
            default:    return 3'sb110;
        endcase
    endfunction

    function automatic logic signed [PW-1:0] mix(input logic [ADC_W-1:0] smp,
                                                 input logic signed [2:0] coef);
        logic signed [PW-1:0] smp_x;
        logic signed [PW-1:0] coef_x;
        smp_x  = {{2{smp[ADC_W-1]}}, smp};
        coef_x = {{(PW-3){coef[2]}}, coef};
        return smp_x * coef_x;
    endfunction

    // Returns {saturated, clamped sum}; one guard bit detects overflow.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [PW-1:0] p);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W+1-PW){p[PW-1]}}, p};
        if (s[ACC_W] != s[ACC_W-1])
            return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    assign w_per_last = (bus.cfg_period != '0) && (r_per == bus.cfg_period - PER_W'(1));
    assign w_ep       = bus.cfg_enable && (bus.cfg_epoch_sel ? w_per_last : bus.sec_pulse_ed);

    always_comb begin
        w_sat_now = '0;
        for (int k = 0; k < NCH; k++) begin
            logic [PHASE_W-1:0] rate;
            logic [ACC_W:0]     si;
            logic [ACC_W:0]     sq;
            rate     = bus.cfg_rate[k*PHASE_W +: PHASE_W];
            w_nxt[k] = {1'b0, r_phase[k]} + {1'b0, rate};
            if (!rate[PHASE_W-1] && w_nxt[k][PHASE_W])
                w_cyc_nxt[k] = r_cyc[k] + CYC_W'(1);
            else if (rate[PHASE_W-1] && !w_nxt[k][PHASE_W])
                w_cyc_nxt[k] = r_cyc[k] - CYC_W'(1);
            else
                w_cyc_nxt[k] = r_cyc[k];
            si = sat_add(r_acc_i[k], mix(bus.adc_data[k*ADC_W +: ADC_W],
                                         cos_lut(r_phase[k][PHASE_W-1 -: 3])));
            sq = sat_add(r_acc_q[k], mix(bus.adc_data[k*ADC_W +: ADC_W],
                                         sin_lut(r_phase[k][PHASE_W-1 -: 3])));
            w_acc_i[k]   = si[ACC_W-1:0];
            w_acc_q[k]   = sq[ACC_W-1:0];
            w_sat_now[k] = si[ACC_W] | sq[ACC_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per       <= '0;
            r_sat       <= '0;
            r_res_i     <= '0;
            r_res_q     <= '0;
            r_res_phase <= '0;
            r_res_cyc   <= '0;
            r_res_sat   <= '0;
            r_valid     <= 1'b0;
            r_ovr       <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                r_phase[k] <= '0;
                r_acc_i[k] <= '0;
                r_acc_q[k] <= '0;
                r_cyc[k]   <= '0;
            end
        end else begin
            if (!bus.cfg_enable || !bus.cfg_epoch_sel || w_per_last)
                r_per <= '0;
            else if (bus.cfg_period != '0)
                r_per <= r_per + PER_W'(1);

            for (int k = 0; k < NCH; k++) begin
                if (!bus.cfg_enable) begin
                    r_phase[k] <= '0;
                    r_acc_i[k] <= '0;
                    r_acc_q[k] <= '0;
                    r_cyc[k]   <= '0;
                    r_sat[k]   <= 1'b0;
                end else if (w_ep) begin
                    r_phase[k] <= bus.cfg_phase_rst ? '0 : w_nxt[k][PHASE_W-1:0];
                    r_acc_i[k] <= '0;
                    r_acc_q[k] <= '0;
                    r_cyc[k]   <= '0;
                    r_sat[k]   <= 1'b0;
                    r_res_i[k*ACC_W +: ACC_W]         <= w_acc_i[k];
                    r_res_q[k*ACC_W +: ACC_W]         <= w_acc_q[k];
                    r_res_phase[k*PHASE_W +: PHASE_W] <= r_phase[k];
                    r_res_cyc[k*CYC_W +: CYC_W]       <= w_cyc_nxt[k];
                    r_res_sat[k] <= r_sat[k] | w_sat_now[k];
                end else begin
                    r_phase[k] <= w_nxt[k][PHASE_W-1:0];
                    r_acc_i[k] <= w_acc_i[k];
                    r_acc_q[k] <= w_acc_q[k];
                    r_cyc[k]   <= w_cyc_nxt[k];
                    r_sat[k]   <= r_sat[k] | w_sat_now[k];
                end
            end

            if (w_ep)
                r_valid <= 1'b1;
            else if (bus.res_ack)
                r_valid <= 1'b0;

            // Setting wins over a same-cycle clear.
            if (w_ep && r_valid && !bus.res_ack)
                r_ovr <= 1'b1;
            else if (bus.ovr_clr)
                r_ovr <= 1'b0;
        end
    end

    assign bus.res_valid   = r_valid;
    assign bus.res_overrun = r_ovr;
    assign bus.res_sat     = r_res_sat;
    assign bus.res_i       = r_res_i;
    assign bus.res_q       = r_res_q;
    assign bus.res_phase   = r_res_phase;
    assign bus.res_cycles  = r_res_cyc;
endmodule
